// File: rtl/tsc_capture_buffer_pkg.sv
// Shared types and constants for the trigger-surround capture buffer.
package tsc_pkg;

  localparam int TSC_TS_W        = 16;
  localparam int TSC_DATA_W_DFLT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_READ
  } tsc_cap_state_t;

endpackage

// File: rtl/tsc_capture_buffer_if.sv
// Sample-in / window-out bundle of the capture buffer.
// TSC_TRIG_TS_EN adds the trig_ts timestamp signal.
interface tsc_capture_buffer_if
  import tsc_pkg::*;
#(
  parameter int DATA_W = TSC_DATA_W_DFLT
);

  logic              smp_vld;
  logic [DATA_W-1:0] smp_dat;
  logic              arm;
  logic              trig;
  logic              busy;
  logic              rd_req;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_dat;
  logic              rd_last;
`ifdef TSC_TRIG_TS_EN
  logic [TSC_TS_W-1:0] trig_ts;
`endif

  // Sample source / host side.
  modport master (
    output smp_vld, smp_dat, arm, trig, rd_req,
`ifdef TSC_TRIG_TS_EN
    input  trig_ts,
`endif
    input  busy, rd_vld, rd_dat, rd_last
  );

  // Capture buffer side.
  modport slave (
    input  smp_vld, smp_dat, arm, trig, rd_req,
`ifdef TSC_TRIG_TS_EN
    output trig_ts,
`endif
    output busy, rd_vld, rd_dat, rd_last
  );

endinterface

// File: rtl/tsc_capture_buffer_sdp_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module tsc_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: data is visible to a read issued on the following edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Registered read port, giving the one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst)        rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/tsc_capture_buffer.sv
// Trigger-surround capture buffer: records samples into a circular store,
// freezes PRE_TRIG samples before the trigger, the trigger sample and the
// rest after it, then plays the DEPTH-sample window out oldest-first.
// Optional feature macro: TSC_TRIG_TS_EN (16-bit trigger timestamp).
//
// state    | meaning
// ST_IDLE  | waiting for arm, no writes
// ST_FILL  | collecting the PRE_TRIG history, trig ignored
// ST_ARMED | circular recording, waiting for smp_vld & trig
// ST_POST  | collecting samples after the trigger
// ST_READ  | window frozen, serving rd_req
module tsc_capture_buffer
  import tsc_pkg::*;
#(
  parameter int DATA_W   = TSC_DATA_W_DFLT,
  parameter int DEPTH    = 32,
  parameter int PRE_TRIG = 8,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst,
  tsc_capture_buffer_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] POST_LEN = PTR_W'(DEPTH - PRE_TRIG - 1);

  tsc_cap_state_t   state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] pre_cnt;
  logic [PTR_W-1:0] post_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             wr_en;
  logic             rd_en;
  logic             trig_hit;

  // Store writes happen only while recording; READ freezes the window.
  always_comb begin
    wr_en    = bus.smp_vld &&
               (state == ST_FILL || state == ST_ARMED || state == ST_POST);
    trig_hit = (state == ST_ARMED) && bus.smp_vld && bus.trig;
    rd_en    = (state == ST_READ) && bus.rd_req && (rd_cnt < CNT_W'(DEPTH));
  end

  // Capture sequencer with registered busy/rd_vld/rd_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      bus.busy    <= 1'b0;
      bus.rd_vld  <= 1'b0;
      bus.rd_last <= 1'b0;
    end else begin
      bus.rd_vld  <= 1'b0;
      bus.rd_last <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.arm) begin
            pre_cnt  <= '0;
            rd_cnt   <= '0;
            bus.busy <= 1'b1;
            state    <= (PRE_TRIG == 0) ? ST_ARMED : ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.smp_vld) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            pre_cnt <= pre_cnt + PTR_W'(1);
            if (pre_cnt == PTR_W'(PRE_TRIG - 1)) state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (bus.smp_vld) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (bus.trig) begin
              // wr_ptr still addresses the trigger sample's slot here.
              rd_ptr   <= wr_ptr - PTR_W'(PRE_TRIG);
              post_cnt <= POST_LEN;
              state    <= (POST_LEN == '0) ? ST_READ : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (bus.smp_vld) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            post_cnt <= post_cnt - PTR_W'(1);
            if (post_cnt == PTR_W'(1)) state <= ST_READ;
          end
        end
        ST_READ: begin
          if (rd_en) begin
            rd_ptr     <= rd_ptr + PTR_W'(1);
            rd_cnt     <= rd_cnt + CNT_W'(1);
            bus.rd_vld <= 1'b1;
            if (rd_cnt == CNT_W'(DEPTH - 1)) begin
              bus.rd_last <= 1'b1;
              bus.busy    <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TSC_TRIG_TS_EN
  logic [TSC_TS_W-1:0] ts_cnt;

  // Free-running sample counter, latched on the trigger sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt      <= '0;
      bus.trig_ts <= '0;
    end else begin
      if (bus.smp_vld) ts_cnt      <= ts_cnt + TSC_TS_W'(1);
      if (trig_hit)    bus.trig_ts <= ts_cnt;
    end
  end
`endif

  tsc_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_dat  (bus.smp_dat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_dat  (bus.rd_dat)
  );

endmodule

// File: doc/tsc_capture_buffer.md
# tsc_capture_buffer

Parametrised trigger-surround capture buffer for the ADC sample path. It continuously records incoming samples into a circular store once armed. On a trigger it freezes a window of `DEPTH` samples: `PRE_TRIG` samples before the trigger, the trigger sample itself, and the remainder after it. It then plays the window out oldest-first over a request/valid read port. It sits between the ADC sample source and the readout/host interface logic.

## Interface
Parameters:
- `DATA_W`, 8: sample width in bits.
- `DEPTH`, 32: window length in samples. Must be a power of two and at least 4.
- `PRE_TRIG`, 8: samples kept before the trigger sample. Legal range is 0 to `DEPTH-1`.
- `PTR_W`, `$clog2(DEPTH)`: derived pointer width. Not to be overridden.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `smp_vld`, in, 1: an ADC sample is present this cycle.
- `smp_dat`, in, `DATA_W`: ADC sample data.
- `arm`, in, 1: start a capture. Honoured only in IDLE.
- `trig`, in, 1: trigger qualifier. Counts only together with `smp_vld` in ARMED.
- `busy`, out, 1: high whenever the state is not IDLE.
- `rd_req`, in, 1: request one word of the window.
- `rd_vld`, out, 1: `rd_dat` is valid this cycle.
- `rd_dat`, out, `DATA_W`: window data, oldest first.
- `rd_last`, out, 1: marks the final (`DEPTH`-th) word. Asserted only together with `rd_vld`.

## Operation
States are IDLE, FILL, ARMED, POST and READ.

- **IDLE**
  - `arm` moves to FILL, or to ARMED if `PRE_TRIG`=0.
  - `pre_cnt` clears on this transition.
  - Samples are not written.
- **FILL**
  - Each `smp_vld` writes `smp_dat` to `mem[wr_ptr]`, increments `wr_ptr` (wrapping modulo `DEPTH`) and increments `pre_cnt`.
  - `trig` is ignored.
  - Moves to ARMED on the cycle the `PRE_TRIG`-th sample is written.
- **ARMED**
  - Keeps writing samples, overwriting the oldest ones.
  - A cycle with `smp_vld & trig` writes the trigger sample and sets `rd_ptr = wr_ptr - PRE_TRIG` (modulo `DEPTH`).
  - On that cycle it loads `post_cnt = DEPTH-PRE_TRIG-1` and moves to POST. If that count is 0 it moves straight to READ.
- **POST**
  - Each `smp_vld` writes a sample and decrements `post_cnt`.
  - The write that brings `post_cnt` to 0 moves to READ.
  - `trig` is ignored.
- **READ**
  - No writes; `smp_vld` is dropped.
  - Each cycle with `rd_req` high while `rd_cnt < DEPTH` accepts one word: reads `mem[rd_ptr]`, increments `rd_ptr` (wrapping) and increments `rd_cnt`.
  - On the acceptance with `rd_cnt = DEPTH-1` it moves to IDLE.
  - Requests made in any other state are ignored.
- `arm` outside IDLE is ignored. A trigger during FILL is lost and is not queued.
- Memory contents are not cleared by reset or between captures.

## Timing
- Reset values:
  - Outputs: `busy`, `rd_vld`, `rd_last` = 0 and `rd_dat` = 0.
  - State is IDLE.
  - `wr_ptr`, `rd_ptr`, `pre_cnt`, `post_cnt`, `rd_cnt` = 0.
- Reset mid-capture: the block is in IDLE with all outputs at reset value from the next cycle. An `arm` in the cycle after reset deasserts is honoured.
- `busy` is registered. It rises the cycle after `arm` is accepted and falls the cycle after the final read acceptance.
- Write latency: a sample written on edge N is readable from edge N+1. Write and read never coincide, because READ performs no writes.
- Read latency is one cycle.
  - A request accepted on edge N gives `rd_vld` = 1 with the data during cycle N+1.
  - `rd_req` held high gives one word per cycle. Gaps are allowed and no word is lost.
- `rd_last` and the final `rd_vld` appear in the first cycle back in IDLE.
- `rd_vld` is a pulse; it is never held without a new acceptance.

## Configuration
`TSC_TRIG_TS_EN` adds a trigger timestamp.

- **Defined:**
  - Adds output `trig_ts` (out, 16): the value of a 16-bit counter captured on the trigger sample.
  - The counter increments on every `smp_vld` in any state, wraps modulo 2^16 and resets to 0. `trig_ts` resets to 0.
  - `trig_ts` holds its value until the next trigger.
- **Undefined:** neither the port nor the counter exists. All other behaviour is identical.

## Structure
- Package `tsc_pkg` holds:
  - the state enum `tsc_cap_state_t`;
  - constant `TSC_TS_W` = 16;
  - the default `DATA_W`.
- Sub-module `tsc_sdp_ram`: simple dual-port RAM, `DATA_W` x `DEPTH`, with a write port and a registered synchronous read port. It supplies the one-cycle read latency. No reset on the array.

## Test plan
Scenarios use `DEPTH`=32 and `PRE_TRIG`=8 unless stated.

1. **Reset:** assert `rst` for 2 cycles with random inputs. Then `busy`, `rd_vld`, `rd_last` = 0; `rd_req` produces no `rd_vld`.
2. **Basic capture:**
   - Stimulus: `arm` with ramp samples 0,1,2,… on every cycle; `trig` with sample 20; `rd_req` held high.
   - Required: 32 words 12..43 on consecutive cycles; `rd_last` only on 43; `busy` falls one cycle after the last acceptance.
3. **Early trigger:**
   - Stimulus: `trig` pulsed at sample 3 (still FILL), then at sample 10.
   - Required: window 2..33.
4. **Wrap-around and dropped samples:**
   - Stimulus: arm, trigger at sample 100 with `smp_vld` on alternate cycles; feed samples during READ.
   - Required: window 92..123 contiguous; samples fed during READ do not alter the window.
5. **Gapped read:**
   - Stimulus: `rd_req` pattern 1,0,0,1,1,0,…
   - Required: one `rd_vld` per accepted request, one cycle later, in order. A 33rd request yields nothing. Repeat with `PRE_TRIG`=0 (window 20..51) and `PRE_TRIG`=31 (window −11..20 mod ramp, READ entered on the trigger sample).
6. **Reset mid-POST:**
   - Stimulus: `rst` for 1 cycle in POST.
   - Required: `busy` = 0 next cycle. A fresh arm and trigger at sample 50 yields 42..73.
   - With `TSC_TRIG_TS_EN` defined, `trig_ts` equals the sample count since reset at the trigger.
